rr_arb4: RTL

RR_ARB4 -- requirements
Module: rr_arb4

---
 rtl/rr_arb4.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rr_arb4.sv
// rr_arb4: 4-requester round-robin arbiter with a registered 4:1 mux select.
// One grant is issued per handshake (o_valid & i_ready). On a handshake the
// priority pointer advances past the served requester, and the next winner
// is registered on the same edge, so back-to-back grants have no bubble.
// Optional feature macro ARB_LOCK_EN: adds i_lock, which lets the current
// requester keep the grant for up to MAX_HOLD consecutive beats.
module rr_arb4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic       i_ready,
`ifdef ARB_LOCK_EN
    input  logic       i_lock,
`endif
    output logic       o_valid,
    output logic [1:0] o_sel,
    output logic [3:0] o_gnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // MAX_HOLD must fit the 8-bit hold counter and allow at least one grant.
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arb4: MAX_HOLD must be in 1..255");
    end

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic       hs;
    logic       keep;
    logic [1:0] next_ptr;

`ifdef ARB_LOCK_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;

    // The lock only extends a grant that is still requested and under the hold limit.
    assign keep = i_lock && i_req[sel_q] && (hold_q < HOLD_LIM);
`else
    assign keep = 1'b0;
`endif

    // First set request at or above ptr, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign hs       = (state_q == GRANT) && i_ready;
    assign next_ptr = sel_q + 2'd1;

    // State register: reset overrides everything, including a pending handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
`ifdef ARB_LOCK_EN
            hold_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef ARB_LOCK_EN
            hold_q  <= hold_d;
`endif
        end
    end

    // Next-state logic: arbitrate from IDLE, or rotate/re-grant on a handshake.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef ARB_LOCK_EN
        hold_d  = hold_q;
`endif
        if (state_q == IDLE) begin
            if (|i_req) begin
                state_d = GRANT;
                sel_d   = rr_pick(i_req, ptr_q);
            end
        end else if (hs) begin
            if (keep) begin
`ifdef ARB_LOCK_EN
                hold_d = hold_q + 8'd1;
`endif
            end else begin
`ifdef ARB_LOCK_EN
                hold_d = 8'd0;
`endif
                ptr_d = next_ptr;
                if (|i_req) begin
                    sel_d = rr_pick(i_req, next_ptr);
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    // Outputs: decoded purely from registered state.
    always_comb begin
        o_valid = (state_q == GRANT);
        o_sel   = sel_q;
        o_gnt   = 4'b0000;
        if (state_q == GRANT) begin
            o_gnt[sel_q] = 1'b1;
        end
    end

endmodule
